// File: rtl/easy_axi_rd_slv.sv
// easy_axi_rd_slv: AXI read slave returning an address-pattern burst per AR request.
// Read data equals the beat address, so traffic can be checked without a memory model.
// Optional one-entry AR buffer enabled by defining EASY_AXI_SLV_AR_BUF_EN.
module easy_axi_rd_slv #(
    parameter int unsigned       ID_W       = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       LEN_W      = 8,
    parameter int unsigned       RD_LAT     = 2,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_1000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              axi_slv_arvalid,
    output logic              axi_slv_arready,
    input  logic [ID_W-1:0]   axi_slv_arid,
    input  logic [ADDR_W-1:0] axi_slv_araddr,
    input  logic [LEN_W-1:0]  axi_slv_arlen,
    input  logic [2:0]        axi_slv_arsize,
    input  logic [1:0]        axi_slv_arburst,
    output logic              axi_slv_rvalid,
    input  logic              axi_slv_rready,
    output logic [ID_W-1:0]   axi_slv_rid,
    output logic [DATA_W-1:0] axi_slv_rdata,
    output logic [1:0]        axi_slv_rresp,
    output logic              axi_slv_rlast
);

    localparam int unsigned LAT_W    = 4;
    localparam int unsigned SIZE_MAX = $clog2(DATA_W / 8);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address of the beat following addr; reserved bursts advance like INCR.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [1:0]        burst,
        input logic [LEN_W-1:0]  len
    );
        logic [ADDR_W-1:0] bytes;
        logic [ADDR_W-1:0] wrap_bytes;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] incr;
        bytes      = ADDR_W'(1) << size;
        wrap_bytes = (ADDR_W'(len) + ADDR_W'(1)) << size;
        base       = addr & ~(wrap_bytes - ADDR_W'(1));
        incr       = addr + bytes;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (incr == base + wrap_bytes) ? base : incr;
            default:     next_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
        endcase
    endfunction

    // Response for one beat: burst-wide errors plus the per-beat address limit.
    function automatic logic [1:0] beat_resp(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [1:0]        burst,
        input logic [LEN_W-1:0]  len
    );
        logic wrap_len_ok;
        logic err;
        wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                      (len == LEN_W'(7)) || (len == LEN_W'(15));
        err = (size > 3'(SIZE_MAX)) || (burst == BURST_RSVD) ||
              ((burst == BURST_WRAP) && !wrap_len_ok) || (addr >= ADDR_LIMIT);
        beat_resp = err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    logic [1:0]        state_q,   state_nxt;
    logic [ID_W-1:0]   id_q,      id_nxt;
    logic [ADDR_W-1:0] addr_q,    addr_nxt;
    logic [LEN_W-1:0]  len_q,     len_nxt;
    logic [2:0]        size_q,    size_nxt;
    logic [1:0]        burst_q,   burst_nxt;
    logic [LEN_W-1:0]  beat_q,    beat_nxt;
    logic [LAT_W-1:0]  lat_q,     lat_nxt;

    logic              arready_nxt;
    logic              rvalid_nxt;
    logic [ID_W-1:0]   rid_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [1:0]        rresp_nxt;
    logic              rlast_nxt;

    logic              ar_hs;
    logic              start_port;
    logic              start_buf;
    logic              present;
    logic [ADDR_W-1:0] pres_addr;
    logic [LEN_W-1:0]  pres_beat;

`ifdef EASY_AXI_SLV_AR_BUF_EN
    logic              buf_valid_q, buf_valid_nxt;
    logic [ID_W-1:0]   buf_id_q,    buf_id_nxt;
    logic [ADDR_W-1:0] buf_addr_q,  buf_addr_nxt;
    logic [LEN_W-1:0]  buf_len_q,   buf_len_nxt;
    logic [2:0]        buf_size_q,  buf_size_nxt;
    logic [1:0]        buf_burst_q, buf_burst_nxt;
`endif

    // State, burst context and registered AXI outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            beat_q          <= '0;
            lat_q           <= '0;
            axi_slv_arready <= 1'b0;
            axi_slv_rvalid  <= 1'b0;
            axi_slv_rid     <= '0;
            axi_slv_rdata   <= '0;
            axi_slv_rresp   <= '0;
            axi_slv_rlast   <= 1'b0;
`ifdef EASY_AXI_SLV_AR_BUF_EN
            buf_valid_q     <= 1'b0;
            buf_id_q        <= '0;
            buf_addr_q      <= '0;
            buf_len_q       <= '0;
            buf_size_q      <= '0;
            buf_burst_q     <= '0;
`endif
        end else begin
            state_q         <= state_nxt;
            id_q            <= id_nxt;
            addr_q          <= addr_nxt;
            len_q           <= len_nxt;
            size_q          <= size_nxt;
            burst_q         <= burst_nxt;
            beat_q          <= beat_nxt;
            lat_q           <= lat_nxt;
            axi_slv_arready <= arready_nxt;
            axi_slv_rvalid  <= rvalid_nxt;
            axi_slv_rid     <= rid_nxt;
            axi_slv_rdata   <= rdata_nxt;
            axi_slv_rresp   <= rresp_nxt;
            axi_slv_rlast   <= rlast_nxt;
`ifdef EASY_AXI_SLV_AR_BUF_EN
            buf_valid_q     <= buf_valid_nxt;
            buf_id_q        <= buf_id_nxt;
            buf_addr_q      <= buf_addr_nxt;
            buf_len_q       <= buf_len_nxt;
            buf_size_q      <= buf_size_nxt;
            buf_burst_q     <= buf_burst_nxt;
`endif
        end
    end

    // Next-state, beat sequencing and next values of every registered output.
    always_comb begin
        state_nxt   = state_q;
        id_nxt      = id_q;
        addr_nxt    = addr_q;
        len_nxt     = len_q;
        size_nxt    = size_q;
        burst_nxt   = burst_q;
        beat_nxt    = beat_q;
        lat_nxt     = lat_q;
        arready_nxt = axi_slv_arready;
        rvalid_nxt  = axi_slv_rvalid;
        rid_nxt     = axi_slv_rid;
        rdata_nxt   = axi_slv_rdata;
        rresp_nxt   = axi_slv_rresp;
        rlast_nxt   = axi_slv_rlast;
        ar_hs       = axi_slv_arvalid && axi_slv_arready;
        start_port  = 1'b0;
        start_buf   = 1'b0;
        present     = 1'b0;
        pres_addr   = addr_q;
        pres_beat   = beat_q;
`ifdef EASY_AXI_SLV_AR_BUF_EN
        buf_valid_nxt = buf_valid_q;
        buf_id_nxt    = buf_id_q;
        buf_addr_nxt  = buf_addr_q;
        buf_len_nxt   = buf_len_q;
        buf_size_nxt  = buf_size_q;
        buf_burst_nxt = buf_burst_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    start_port = 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_nxt  = ST_DATA;
                    rvalid_nxt = 1'b1;
                    present    = 1'b1;
                end else begin
                    lat_nxt = lat_q - LAT_W'(1);
                end
            end
            ST_DATA: begin
                if (axi_slv_rvalid && axi_slv_rready) begin
                    if (axi_slv_rlast) begin
                        rvalid_nxt = 1'b0;
                        rlast_nxt  = 1'b0;
                        state_nxt  = ST_IDLE;
`ifdef EASY_AXI_SLV_AR_BUF_EN
                        if (buf_valid_q) begin
                            start_buf = 1'b1;
                        end else if (ar_hs) begin
                            start_port = 1'b1;
                        end
`endif
                    end else begin
                        pres_addr = next_addr(addr_q, size_q, burst_q, len_q);
                        pres_beat = beat_q + LEN_W'(1);
                        addr_nxt  = pres_addr;
                        beat_nxt  = pres_beat;
                        present   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Load burst context from the AR port.
        if (start_port) begin
            id_nxt    = axi_slv_arid;
            addr_nxt  = axi_slv_araddr;
            len_nxt   = axi_slv_arlen;
            size_nxt  = axi_slv_arsize;
            burst_nxt = axi_slv_arburst;
        end

`ifdef EASY_AXI_SLV_AR_BUF_EN
        // Pop the buffered request, or park a request accepted while busy.
        if (start_buf) begin
            id_nxt        = buf_id_q;
            addr_nxt      = buf_addr_q;
            len_nxt       = buf_len_q;
            size_nxt      = buf_size_q;
            burst_nxt     = buf_burst_q;
            buf_valid_nxt = 1'b0;
        end
        if (ar_hs && !start_port) begin
            buf_valid_nxt = 1'b1;
            buf_id_nxt    = axi_slv_arid;
            buf_addr_nxt  = axi_slv_araddr;
            buf_len_nxt   = axi_slv_arlen;
            buf_size_nxt  = axi_slv_arsize;
            buf_burst_nxt = axi_slv_arburst;
        end
`endif

        if (start_port || start_buf) begin
            beat_nxt  = '0;
            lat_nxt   = LAT_W'(RD_LAT);
            state_nxt = ST_WAIT;
        end

        // Build the R fields of the beat that becomes visible next cycle.
        if (present) begin
            rid_nxt   = id_q;
            rresp_nxt = beat_resp(pres_addr, size_q, burst_q, len_q);
            rdata_nxt = (rresp_nxt == RESP_SLVERR) ? '0 : DATA_W'(pres_addr);
            rlast_nxt = (pres_beat == len_q);
        end

`ifdef EASY_AXI_SLV_AR_BUF_EN
        arready_nxt = !buf_valid_nxt;
`else
        arready_nxt = (state_nxt == ST_IDLE);
`endif
    end

endmodule

// File: tb/tb_easy_axi_rd_slv.sv
// tb_easy_axi_rd_slv: directed vector bench for easy_axi_rd_slv (default parameters, RD_LAT=2).
// Buffered-AR sequence is compiled in when EASY_AXI_SLV_AR_BUF_EN is defined.
module tb_easy_axi_rd_slv;

    localparam int unsigned RD_LAT = 2;
    localparam int          NV     = 11;
    localparam logic [1:0]  OK     = 2'b00;
    localparam logic [1:0]  SE     = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        axi_slv_arvalid;
    logic        axi_slv_arready;
    logic [3:0]  axi_slv_arid;
    logic [31:0] axi_slv_araddr;
    logic [7:0]  axi_slv_arlen;
    logic [2:0]  axi_slv_arsize;
    logic [1:0]  axi_slv_arburst;
    logic        axi_slv_rvalid;
    logic        axi_slv_rready;
    logic [3:0]  axi_slv_rid;
    logic [31:0] axi_slv_rdata;
    logic [1:0]  axi_slv_rresp;
    logic        axi_slv_rlast;

    typedef struct packed {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             stall;
        logic [0:7][31:0] data;
        logic [0:7][1:0]  resp;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec;
    int   n_err;

    easy_axi_rd_slv dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (axi_slv_arvalid),
        .axi_slv_arready (axi_slv_arready),
        .axi_slv_arid    (axi_slv_arid),
        .axi_slv_araddr  (axi_slv_araddr),
        .axi_slv_arlen   (axi_slv_arlen),
        .axi_slv_arsize  (axi_slv_arsize),
        .axi_slv_arburst (axi_slv_arburst),
        .axi_slv_rvalid  (axi_slv_rvalid),
        .axi_slv_rready  (axi_slv_rready),
        .axi_slv_rid     (axi_slv_rid),
        .axi_slv_rdata   (axi_slv_rdata),
        .axi_slv_rresp   (axi_slv_rresp),
        .axi_slv_rlast   (axi_slv_rlast)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the run stalls somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ar(input int i);
        axi_slv_arvalid = 1'b1;
        axi_slv_arid    = vecs[i].id;
        axi_slv_araddr  = vecs[i].addr;
        axi_slv_arlen   = vecs[i].len;
        axi_slv_arsize  = vecs[i].size;
        axi_slv_arburst = vecs[i].burst;
    endtask

    // Present AR at a negedge, hold until accepted; returns at the negedge after the handshake.
    task automatic send_ar(input int i);
        int g;
        g = 0;
        drive_ar(i);
        while (!axi_slv_arready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("v%0d arready", i), 64'(axi_slv_arready), 64'd1);
        @(negedge clk);
        axi_slv_arvalid = 1'b0;
    endtask

    // Called at the negedge after the starting edge; counts cycles to first rvalid.
    task automatic wait_first(input string tag);
        int lat;
        lat = 0;
        while (!axi_slv_rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), 64'(lat), 64'(RD_LAT + 1));
    endtask

    // Consume all beats of vector i, checking every visible cycle including stalls.
    task automatic collect(input int i);
        int   beat;
        int   guard;
        logic ph;
        beat  = 0;
        guard = 0;
        ph    = 1'b1;
        while (beat <= int'(vecs[i].len) && guard < 100) begin
            axi_slv_rready = vecs[i].stall ? ph : 1'b1;
            ph = ~ph;
            chk($sformatf("v%0d b%0d rvalid", i, beat), 64'(axi_slv_rvalid), 64'd1);
            if (axi_slv_rvalid) begin
                chk($sformatf("v%0d b%0d rid", i, beat), 64'(axi_slv_rid), 64'(vecs[i].id));
                chk($sformatf("v%0d b%0d rdata", i, beat), 64'(axi_slv_rdata), 64'(vecs[i].data[beat]));
                chk($sformatf("v%0d b%0d rresp", i, beat), 64'(axi_slv_rresp), 64'(vecs[i].resp[beat]));
                chk($sformatf("v%0d b%0d rlast", i, beat), 64'(axi_slv_rlast),
                    64'(beat == int'(vecs[i].len)));
                if (axi_slv_rready) beat++;
            end
            @(negedge clk);
            guard++;
        end
        axi_slv_rready = 1'b0;
        chk($sformatf("v%0d beat count", i), 64'(beat), 64'(int'(vecs[i].len) + 1));
        chk($sformatf("v%0d rvalid after last", i), 64'(axi_slv_rvalid), 64'd0);
        chk($sformatf("v%0d arready after last", i), 64'(axi_slv_arready), 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        axi_slv_arvalid = 1'b0;
        axi_slv_arid    = '0;
        axi_slv_araddr  = '0;
        axi_slv_arlen   = '0;
        axi_slv_arsize  = '0;
        axi_slv_arburst = '0;
        axi_slv_rready  = 1'b0;

        vecs[0]  = '{id: 4'd3, addr: 32'h10, len: 8'd3, size: 3'd2, burst: 2'b01, stall: 1'b0,
                     data: {32'h10, 32'h14, 32'h18, 32'h1C, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[1]  = '{id: 4'd5, addr: 32'h18, len: 8'd3, size: 3'd2, burst: 2'b10, stall: 1'b0,
                     data: {32'h18, 32'h1C, 32'h10, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[2]  = '{id: 4'd6, addr: 32'h18, len: 8'd2, size: 3'd2, burst: 2'b10, stall: 1'b0,
                     data: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {SE, SE, SE, OK, OK, OK, OK, OK}};
        vecs[3]  = '{id: 4'd7, addr: 32'h40, len: 8'd2, size: 3'd2, burst: 2'b00, stall: 1'b1,
                     data: {32'h40, 32'h40, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[4]  = '{id: 4'd9, addr: 32'hFF8, len: 8'd3, size: 3'd2, burst: 2'b01, stall: 1'b0,
                     data: {32'hFF8, 32'hFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, SE, SE, OK, OK, OK, OK}};
        vecs[5]  = '{id: 4'd2, addr: 32'h100, len: 8'd1, size: 3'd3, burst: 2'b01, stall: 1'b0,
                     data: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {SE, SE, OK, OK, OK, OK, OK, OK}};
        vecs[6]  = '{id: 4'd1, addr: 32'h20, len: 8'd1, size: 3'd2, burst: 2'b11, stall: 1'b0,
                     data: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {SE, SE, OK, OK, OK, OK, OK, OK}};
        vecs[7]  = '{id: 4'd12, addr: 32'h21, len: 8'd2, size: 3'd2, burst: 2'b01, stall: 1'b0,
                     data: {32'h21, 32'h24, 32'h28, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[8]  = '{id: 4'd14, addr: 32'h32, len: 8'd1, size: 3'd1, burst: 2'b10, stall: 1'b1,
                     data: {32'h32, 32'h30, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[9]  = '{id: 4'd15, addr: 32'hFFC, len: 8'd0, size: 3'd2, burst: 2'b01, stall: 1'b0,
                     data: {32'hFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};
        vecs[10] = '{id: 4'd10, addr: 32'h80, len: 8'd7, size: 3'd0, burst: 2'b01, stall: 1'b1,
                     data: {32'h80, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86, 32'h87},
                     resp: {OK, OK, OK, OK, OK, OK, OK, OK}};

        // Reset values, then arready rises on the first edge after release.
        repeat (2) @(negedge clk);
        chk("reset arready", 64'(axi_slv_arready), 64'd0);
        chk("reset rvalid", 64'(axi_slv_rvalid), 64'd0);
        chk("reset rid", 64'(axi_slv_rid), 64'd0);
        chk("reset rdata", 64'(axi_slv_rdata), 64'd0);
        chk("reset rresp", 64'(axi_slv_rresp), 64'd0);
        chk("reset rlast", 64'(axi_slv_rlast), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready after release", 64'(axi_slv_arready), 64'd1);

        // Table of single bursts.
        for (int i = 0; i < NV; i++) begin
            send_ar(i);
            chk($sformatf("v%0d arready after AR", i), 64'(axi_slv_arready),
`ifdef EASY_AXI_SLV_AR_BUF_EN
                64'd1);
`else
                64'd0);
`endif
            wait_first($sformatf("v%0d", i));
            collect(i);
        end

`ifdef EASY_AXI_SLV_AR_BUF_EN
        // Second AR accepted during DATA, buffered, then popped straight into WAIT.
        send_ar(0);
        wait_first("buf first");
        drive_ar(1);
        chk("buf accept arready", 64'(axi_slv_arready), 64'd1);
        @(negedge clk);
        axi_slv_arvalid = 1'b0;
        chk("buf full arready", 64'(axi_slv_arready), 64'd0);
        chk("buf first rvalid held", 64'(axi_slv_rvalid), 64'd1);
        collect(0);
        wait_first("buf second");
        collect(1);
`else
        // Without the buffer, no AR is accepted while a burst is active.
        send_ar(0);
        wait_first("nobuf");
        chk("nobuf arready in DATA", 64'(axi_slv_arready), 64'd0);
        collect(0);
`endif

        // Asynchronous reset during beat 1 of a len=7 burst.
        send_ar(10);
        wait_first("rst burst");
        axi_slv_rready = 1'b1;
        @(negedge clk);
        chk("rst beat1 rvalid", 64'(axi_slv_rvalid), 64'd1);
        chk("rst beat1 rdata", 64'(axi_slv_rdata), 64'h81);
        #2 rst_n = 1'b0;
        #1;
        chk("rst rvalid drop", 64'(axi_slv_rvalid), 64'd0);
        chk("rst rlast drop", 64'(axi_slv_rlast), 64'd0);
        chk("rst arready", 64'(axi_slv_arready), 64'd0);
        axi_slv_rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst arready before edge", 64'(axi_slv_arready), 64'd0);
        @(negedge clk);
        chk("rst arready after release", 64'(axi_slv_arready), 64'd1);
        chk("rst rvalid after release", 64'(axi_slv_rvalid), 64'd0);

        // Clean burst after the aborted one.
        send_ar(0);
        wait_first("recover");
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
